// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller: state encodings,
// digit width and the default debounce interval for a 50 MHz board clock.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      LAP   = 2'd2,
      PAUSE = 2'd3
   } sw_state_t;

   localparam int DIGIT_W       = 4;
   localparam int CLK_HZ        = 50_000_000;
   localparam int DB_CYCLES_DEF = 1_000_000;

endpackage

// File: rtl/btn_debounce.sv
// Debounces one raw push-button: 2-flop synchronizer, hold-time counter,
// and a one-cycle registered pulse on each accepted press (0->1 of level).
module btn_debounce #(
   parameter int DB_CYCLES = 1_000_000,
   parameter int DB_W      = 20
) (
   input  logic clk,
   input  logic clr,
   input  logic btn_raw,
   output logic level,
   output logic press
);

   localparam logic [DB_W-1:0] CNT_MAX = DB_W'(DB_CYCLES - 1);

   logic            sync1;
   logic            sync2;
   logic [DB_W-1:0] cnt;

   // Bring the asynchronous button level into the clk domain
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
      end
   end

   // Accept a new level only after it has differed for DB_CYCLES cycles in a row
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         cnt   <= '0;
         level <= 1'b0;
         press <= 1'b0;
      end else begin
         press <= 1'b0;
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            level <= sync2;
            press <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode controller: turns debounced start/stop and lap/reset presses
// into go/stop/timer_clr pulses for the timer and selects live or lap digits
// for the display.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEF,
   parameter int DB_W      = 20
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               btn_ss,
   input  logic               btn_lap,
   input  logic [DIGIT_W-1:0] d3,
   input  logic [DIGIT_W-1:0] d2,
   input  logic [DIGIT_W-1:0] d1,
   input  logic [DIGIT_W-1:0] d0,
   output logic               go,
   output logic               stop,
   output logic               timer_clr,
   output logic [DIGIT_W-1:0] disp3,
   output logic [DIGIT_W-1:0] disp2,
   output logic [DIGIT_W-1:0] disp1,
   output logic [DIGIT_W-1:0] disp0,
   output logic               running,
   output logic               lap_led
);

   sw_state_t                 state;
   sw_state_t                 state_nxt;
   logic                      go_nxt;
   logic                      stop_nxt;
   logic                      tclr_nxt;
   logic                      capture;
   logic [4*DIGIT_W-1:0]      lap_q;
   logic                      ssp;
   logic                      lapp;
   logic                      unused_ss_level;
   logic                      unused_lap_level;

   btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_ss (
      .clk     (clk),
      .clr     (clr),
      .btn_raw (btn_ss),
      .level   (unused_ss_level),
      .press   (ssp)
   );

   btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_lap (
      .clk     (clk),
      .clr     (clr),
      .btn_raw (btn_lap),
      .level   (unused_lap_level),
      .press   (lapp)
   );

   // Mode transitions; start/stop takes priority when both presses coincide
   always_comb begin
      state_nxt = state;
      go_nxt    = 1'b0;
      stop_nxt  = 1'b0;
      tclr_nxt  = 1'b0;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            if (ssp) begin
               state_nxt = RUN;
               go_nxt    = 1'b1;
            end
         end
         RUN: begin
            if (ssp) begin
               state_nxt = PAUSE;
               stop_nxt  = 1'b1;
            end else if (lapp) begin
               state_nxt = LAP;
               capture   = 1'b1;
            end
         end
         LAP: begin
            if (ssp) begin
               state_nxt = PAUSE;
               stop_nxt  = 1'b1;
            end else if (lapp) begin
               state_nxt = RUN;
            end
         end
         PAUSE: begin
            if (ssp) begin
               state_nxt = RUN;
               go_nxt    = 1'b1;
            end else if (lapp) begin
               state_nxt = IDLE;
               tclr_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, one-cycle timer command pulses and the lap snapshot
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state     <= IDLE;
         go        <= 1'b0;
         stop      <= 1'b0;
         timer_clr <= 1'b0;
         lap_q     <= '0;
      end else begin
         state     <= state_nxt;
         go        <= go_nxt;
         stop      <= stop_nxt;
         timer_clr <= tclr_nxt;
         if (capture) begin
            lap_q <= {d3, d2, d1, d0};
         end
      end
   end

   // Status LEDs and display source come straight from the registered state
   always_comb begin
      running = (state == RUN) || (state == LAP);
      lap_led = (state == LAP);
      if (state == LAP) begin
         {disp3, disp2, disp1, disp0} = lap_q;
      end else begin
         {disp3, disp2, disp1, disp0} = {d3, d2, d1, d0};
      end
   end

endmodule
